// File: rtl/rv32i_multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle RV32I controller.
// master = controller side, slave = datapath/memory side.
interface rv32i_multicycle_control_if;
    logic [31:0] iInst_Code;
    logic        iBtaken;
    logic        iMem_Ready;
    logic        oIR_En;
    logic        oPC_En;
    logic [1:0]  oPC_Sel;
    logic [2:0]  oFunct3;
    logic [3:0]  oALU_Control;
    logic        oALUSrcMuxSel1;
    logic        oALUSrcMuxSel2;
    logic [1:0]  oRegWrDataSel;
    logic        oWrEn;
    logic        oData_WrEn;
    logic        oData_RdEn;
    logic        oTrap;
    logic [1:0]  oTrapCause;
    logic [2:0]  oState;

    modport master (
        input  iInst_Code, iBtaken, iMem_Ready,
        output oIR_En, oPC_En, oPC_Sel, oFunct3, oALU_Control, oALUSrcMuxSel1,
               oALUSrcMuxSel2, oRegWrDataSel, oWrEn, oData_WrEn, oData_RdEn,
               oTrap, oTrapCause, oState
    );

    modport slave (
        output iInst_Code, iBtaken, iMem_Ready,
        input  oIR_En, oPC_En, oPC_Sel, oFunct3, oALU_Control, oALUSrcMuxSel1,
               oALUSrcMuxSel2, oRegWrDataSel, oWrEn, oData_WrEn, oData_RdEn,
               oTrap, oTrapCause, oState
    );
endinterface

// File: rtl/rv32i_multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences one shared ALU/memory port, waits on
// data-memory ready with a timeout, and halts in a sticky TRAP state.
//
// state   | meaning
// FETCH   | latch instruction into rInst and the datapath IR
// DECODE  | classify opcode; illegal -> TRAP or skip as NOP
// EXECUTE | ALU op, write-back and PC update for non-memory instructions
// MEM     | hold load/store request until ready, timeout or single cycle
// WB      | write load data to the register file
// TRAP    | halted until reset, cause held
module rv32i_multicycle_control #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_TIMEOUT   = 15,
    parameter bit          TRAP_ILLEGAL  = 1'b1
) (
    input logic iClk,
    input logic iRst,
    rv32i_multicycle_control_if.master bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_R, OP_I, OP_L, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BAD
    } opClass_t;

    state_t         state, stateNext;
    opClass_t       opClass;
    logic [31:0]    rInst;
    logic [CNT_W-1:0] waitCnt;
    logic [1:0]     trapCause, causeNext;
    logic           setCause, loadWait, decWait;
    logic           memDone, memTimeout;
    logic [2:0]     funct3;

    logic           irEn, pcEn, sel1, sel2, wrEn, dataWrEn, dataRdEn;
    logic [1:0]     pcSel, wrDataSel;
    logic [3:0]     aluCtl;

    logic unusedInstBits;
    assign unusedInstBits = ^{rInst[31], rInst[29:15], rInst[11:7]};

    assign funct3 = rInst[14:12];

    always_comb begin
        unique case (rInst[6:0])
            7'b0110011: opClass = OP_R;
            7'b0010011: opClass = OP_I;
            7'b0000011: opClass = OP_L;
            7'b0100011: opClass = OP_S;
            7'b1100011: opClass = OP_B;
            7'b0110111: opClass = OP_LUI;
            7'b0010111: opClass = OP_AUIPC;
            7'b1101111: opClass = OP_JAL;
            7'b1100111: opClass = OP_JALR;
            default:    opClass = OP_BAD;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= FETCH;
            rInst     <= '0;
            waitCnt   <= '0;
            trapCause <= 2'b00;
        end else begin
            state <= stateNext;
            if (state == FETCH) rInst <= bus.iInst_Code;
            // Down-counter: loaded with the budget, timeout at terminal count 0.
            if (loadWait) waitCnt <= WAIT_LOAD;
            else if (decWait) waitCnt <= waitCnt - CNT_W'(1);
            if (setCause) trapCause <= causeNext;
        end
    end

    assign memDone    = bus.iMem_Ready || !MEM_HANDSHAKE;
    assign memTimeout = (MEM_TIMEOUT != 0) && (waitCnt == '0) && !bus.iMem_Ready;

    always_comb begin
        stateNext = state;
        irEn      = 1'b0;
        pcEn      = 1'b0;
        pcSel     = 2'b00;
        aluCtl    = 4'b0000;
        sel1      = 1'b0;
        sel2      = 1'b0;
        wrDataSel = 2'b00;
        wrEn      = 1'b0;
        dataWrEn  = 1'b0;
        dataRdEn  = 1'b0;
        loadWait  = 1'b0;
        decWait   = 1'b0;
        setCause  = 1'b0;
        causeNext = 2'b00;
        if (!iRst) begin
            case (state)
                FETCH: begin
                    irEn      = 1'b1;
                    stateNext = DECODE;
                end
                DECODE: begin
                    if (opClass != OP_BAD) begin
                        stateNext = EXECUTE;
                    end else if (TRAP_ILLEGAL) begin
                        stateNext = TRAP;
                        setCause  = 1'b1;
                        causeNext = 2'b01;
                    end else begin
                        pcEn      = 1'b1;
                        stateNext = FETCH;
                    end
                end
                EXECUTE: begin
                    stateNext = FETCH;
                    case (opClass)
                        OP_R: begin
                            aluCtl = {rInst[30], funct3};
                            wrEn   = 1'b1;
                            pcEn   = 1'b1;
                        end
                        OP_I: begin
                            // Only the shift-right pair uses funct7[5]; ADDI etc. ignore bit 30.
                            aluCtl = (funct3 == 3'b101) ? {rInst[30], funct3} : {1'b0, funct3};
                            sel2   = 1'b1;
                            wrEn   = 1'b1;
                            pcEn   = 1'b1;
                        end
                        OP_LUI: begin
                            wrDataSel = 2'b10;
                            wrEn      = 1'b1;
                            pcEn      = 1'b1;
                        end
                        OP_AUIPC: begin
                            sel1 = 1'b1;
                            sel2 = 1'b1;
                            wrEn = 1'b1;
                            pcEn = 1'b1;
                        end
                        OP_JAL: begin
                            wrDataSel = 2'b11;
                            wrEn      = 1'b1;
                            pcSel     = 2'b01;
                            pcEn      = 1'b1;
                        end
                        OP_JALR: begin
                            wrDataSel = 2'b11;
                            sel2      = 1'b1;
                            wrEn      = 1'b1;
                            pcSel     = 2'b10;
                            pcEn      = 1'b1;
                        end
                        OP_B: begin
                            aluCtl = {1'b0, funct3};
                            pcEn   = 1'b1;
                            pcSel  = bus.iBtaken ? 2'b01 : 2'b00;
                        end
                        OP_L, OP_S: begin
                            sel2      = 1'b1;
                            loadWait  = 1'b1;
                            stateNext = MEM;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    sel2     = 1'b1;
                    dataRdEn = (opClass == OP_L);
                    dataWrEn = (opClass == OP_S);
                    // Ready on the terminal-count cycle still completes the access.
                    if (memDone) begin
                        if (opClass == OP_L) begin
                            stateNext = WB;
                        end else begin
                            pcEn      = 1'b1;
                            stateNext = FETCH;
                        end
                    end else if (memTimeout) begin
                        stateNext = TRAP;
                        setCause  = 1'b1;
                        causeNext = 2'b10;
                    end else begin
                        decWait = (waitCnt != '0);
                    end
                end
                WB: begin
                    wrDataSel = 2'b01;
                    wrEn      = 1'b1;
                    pcEn      = 1'b1;
                    stateNext = FETCH;
                end
                TRAP: stateNext = TRAP;
                default: stateNext = FETCH;
            endcase
        end
    end

    assign bus.oIR_En         = irEn;
    assign bus.oPC_En         = pcEn;
    assign bus.oPC_Sel        = pcSel;
    assign bus.oFunct3        = iRst ? 3'b000 : funct3;
    assign bus.oALU_Control   = aluCtl;
    assign bus.oALUSrcMuxSel1 = sel1;
    assign bus.oALUSrcMuxSel2 = sel2;
    assign bus.oRegWrDataSel  = wrDataSel;
    assign bus.oWrEn          = wrEn;
    assign bus.oData_WrEn     = dataWrEn;
    assign bus.oData_RdEn     = dataRdEn;
    assign bus.oTrap          = !iRst && (state == TRAP);
    assign bus.oTrapCause     = (!iRst && (state == TRAP)) ? trapCause : 2'b00;
    assign bus.oState         = iRst ? 3'd0 : state;

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Bench for rv32i_multicycle_control: two parameterisations driven from
// per-instruction cycle traces built by a behavioural model.
module tb_rv32i_multicycle_control;

    typedef struct packed {
        logic       irEn;
        logic       pcEn;
        logic [1:0] pcSel;
        logic [2:0] funct3;
        logic [3:0] alu;
        logic       sel1;
        logic       sel2;
        logic [1:0] wds;
        logic       wrEn;
        logic       dWr;
        logic       dRd;
        logic       trap;
        logic [1:0] cause;
        logic [2:0] state;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic [31:0] inst;
        logic        bt;
        logic        rdy;
        outs_t       exp;
    } rec_t;

    localparam int C_R = 0, C_I = 1, C_L = 2, C_S = 3, C_B = 4, C_LUI = 5,
                   C_AUIPC = 6, C_JAL = 7, C_JALR = 8, C_BAD = 9;

    logic iClk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1;
    always #5 iClk = ~iClk;

    rv32i_multicycle_control_if bus0 ();
    rv32i_multicycle_control_if bus1 ();

    rv32i_multicycle_control #(.MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(15), .TRAP_ILLEGAL(1'b1))
        dut0 (.iClk(iClk), .iRst(rst0), .bus(bus0));
    rv32i_multicycle_control #(.MEM_HANDSHAKE(1'b0), .MEM_TIMEOUT(3), .TRAP_ILLEGAL(1'b0))
        dut1 (.iClk(iClk), .iRst(rst1), .bus(bus1));

    outs_t act0, act1;
    assign act0 = {bus0.oIR_En, bus0.oPC_En, bus0.oPC_Sel, bus0.oFunct3, bus0.oALU_Control,
                   bus0.oALUSrcMuxSel1, bus0.oALUSrcMuxSel2, bus0.oRegWrDataSel, bus0.oWrEn,
                   bus0.oData_WrEn, bus0.oData_RdEn, bus0.oTrap, bus0.oTrapCause, bus0.oState};
    assign act1 = {bus1.oIR_En, bus1.oPC_En, bus1.oPC_Sel, bus1.oFunct3, bus1.oALU_Control,
                   bus1.oALUSrcMuxSel1, bus1.oALUSrcMuxSel2, bus1.oRegWrDataSel, bus1.oWrEn,
                   bus1.oData_WrEn, bus1.oData_RdEn, bus1.oTrap, bus1.oTrapCause, bus1.oState};

    rec_t q0[$];
    rec_t q1[$];
    int nCmp = 0;
    int nBad = 0;

    // Model state per DUT: last fetched instruction, halted flag, held cause.
    bit          mHandshake [2] = '{1'b1, 1'b0};
    int          mTimeout   [2] = '{15, 3};
    bit          mTrapIll   [2] = '{1'b1, 1'b0};
    logic [31:0] prevInst   [2];
    bit          trapped    [2];
    logic [1:0]  heldCause  [2];

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_L;
            7'b0100011: return C_S;
            7'b1100011: return C_B;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            default:    return C_BAD;
        endcase
    endfunction

    function automatic outs_t blank(input logic [2:0] f3, input logic [2:0] st);
        outs_t o = '0;
        o.funct3 = f3;
        o.state  = st;
        return o;
    endfunction

    task automatic pushRec(input int w, input logic r, input logic [31:0] inst,
                           input logic bt, input logic rdy, input outs_t o);
        rec_t x;
        x.rst = r; x.inst = inst; x.bt = bt; x.rdy = rdy; x.exp = o;
        if (w == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic addReset(input int w, input int n);
        for (int i = 0; i < n; i++) pushRec(w, 1'b1, $urandom(), rb(), rb(), '0);
        prevInst[w]  = '0;
        trapped[w]   = 1'b0;
        heldCause[w] = 2'b00;
    endtask

    task automatic addTrap(input int w, input int n);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = blank(prevInst[w][14:12], 3'd5);
            o.trap  = 1'b1;
            o.cause = heldCause[w];
            pushRec(w, 1'b0, $urandom(), rb(), rb(), o);
        end
    endtask

    // One instruction's full cycle trace. waits = MEM cycles with ready low
    // before ready rises; rstAt >= 0 asserts reset on that MEM cycle.
    task automatic addInst(input int w, input logic [31:0] inst, input bit bt,
                           input int waits, input int rstAt);
        outs_t o;
        int cls = classify(inst[6:0]);
        logic [2:0] f3 = inst[14:12];
        if (trapped[w]) begin
            addTrap(w, 3);
            return;
        end
        o = blank(prevInst[w][14:12], 3'd0);
        o.irEn = 1'b1;
        pushRec(w, 1'b0, inst, rb(), rb(), o);
        prevInst[w] = inst;

        o = blank(f3, 3'd1);
        if (cls == C_BAD) begin
            if (mTrapIll[w]) begin
                pushRec(w, 1'b0, $urandom(), rb(), rb(), o);
                trapped[w] = 1'b1;
                heldCause[w] = 2'b01;
                addTrap(w, 3);
            end else begin
                o.pcEn = 1'b1;
                pushRec(w, 1'b0, $urandom(), rb(), rb(), o);
            end
            return;
        end
        pushRec(w, 1'b0, $urandom(), rb(), rb(), o);

        o = blank(f3, 3'd2);
        case (cls)
            C_R:     begin o.alu = {inst[30], f3}; o.wrEn = 1; o.pcEn = 1; end
            C_I:     begin o.alu = (f3 == 3'b101) ? {inst[30], f3} : {1'b0, f3};
                           o.sel2 = 1; o.wrEn = 1; o.pcEn = 1; end
            C_LUI:   begin o.wds = 2'b10; o.wrEn = 1; o.pcEn = 1; end
            C_AUIPC: begin o.sel1 = 1; o.sel2 = 1; o.wrEn = 1; o.pcEn = 1; end
            C_JAL:   begin o.wds = 2'b11; o.wrEn = 1; o.pcSel = 2'b01; o.pcEn = 1; end
            C_JALR:  begin o.wds = 2'b11; o.sel2 = 1; o.wrEn = 1; o.pcSel = 2'b10; o.pcEn = 1; end
            C_B:     begin o.alu = {1'b0, f3}; o.pcEn = 1; o.pcSel = bt ? 2'b01 : 2'b00; end
            default: o.sel2 = 1;
        endcase
        pushRec(w, 1'b0, $urandom(), bt, rb(), o);
        if (cls != C_L && cls != C_S) return;

        if (!mHandshake[w]) begin
            o = blank(f3, 3'd3);
            o.sel2 = 1; o.dRd = (cls == C_L); o.dWr = (cls == C_S); o.pcEn = (cls == C_S);
            pushRec(w, 1'b0, $urandom(), rb(), rb(), o);
        end else begin
            for (int k = 0; k <= waits; k++) begin
                if (k == rstAt) begin
                    addReset(w, 1);
                    return;
                end
                o = blank(f3, 3'd3);
                o.sel2 = 1; o.dRd = (cls == C_L); o.dWr = (cls == C_S);
                if (k == waits) begin
                    o.pcEn = (cls == C_S);
                    pushRec(w, 1'b0, $urandom(), rb(), 1'b1, o);
                end else begin
                    pushRec(w, 1'b0, $urandom(), rb(), 1'b0, o);
                    if (mTimeout[w] != 0 && k == mTimeout[w]) begin
                        trapped[w] = 1'b1;
                        heldCause[w] = 2'b10;
                        addTrap(w, 3);
                        return;
                    end
                end
            end
        end
        if (cls == C_L) begin
            o = blank(f3, 3'd4);
            o.wds = 2'b01; o.wrEn = 1; o.pcEn = 1;
            pushRec(w, 1'b0, $urandom(), rb(), rb(), o);
        end
    endtask

    function automatic logic [31:0] randInst(input bit allowBad);
        logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        logic [31:0] r = $urandom();
        logic [6:0] op;
        if (allowBad && $urandom_range(0, 9) == 0) begin
            do op = 7'($urandom()); while (classify(op) != C_BAD);
        end else begin
            op = ops[$urandom_range(0, 8)];
        end
        return {r[31:7], op};
    endfunction

    task automatic pin(input string name, input int act, input int req);
        nCmp++;
        if (act != req) begin
            nBad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int countState0(input int from, input int to, input logic [2:0] st);
        int c = 0;
        for (int i = from; i < to; i++) if (q0[i].exp.state == st && !q0[i].rst) c++;
        return c;
    endfunction

    initial begin
        int s, e;
        bus0.iInst_Code = '0; bus0.iBtaken = 0; bus0.iMem_Ready = 0;
        bus1.iInst_Code = '0; bus1.iBtaken = 0; bus1.iMem_Ready = 0;

        // Directed program for the handshake/trapping instance.
        addReset(0, 2);
        s = q0.size(); addInst(0, 32'h002081B3, 0, 0, -1);
        pin("add_cycles", q0.size() - s, 3);
        pin("add_alu", int'(q0[s+2].exp.alu), 4'b0000);
        s = q0.size(); addInst(0, 32'h402081B3, 0, 0, -1);
        pin("sub_alu", int'(q0[s+2].exp.alu), 4'b1000);
        s = q0.size(); addInst(0, 32'h4020D193, 0, 0, -1);
        pin("srai_alu", int'(q0[s+2].exp.alu), 4'b1101);
        s = q0.size(); addInst(0, 32'h40208193, 0, 0, -1);
        pin("addi_b30_alu", int'(q0[s+2].exp.alu), 4'b0000);
        s = q0.size(); addInst(0, 32'h00208463, 1, 0, -1);
        pin("beq_taken_sel", int'(q0[s+2].exp.pcSel), 1);
        addInst(0, 32'h00208463, 0, 0, -1);
        s = q0.size(); addInst(0, 32'h0000A183, 0, 2, -1); e = q0.size();
        pin("lw_cycles", e - s, 7);
        pin("lw_mem_cycles", countState0(s, e, 3'd3), 3);
        s = q0.size(); addInst(0, 32'h0020A023, 0, 0, -1);
        pin("sw_cycles", q0.size() - s, 4);
        addInst(0, 32'h123450B7, 0, 0, -1);
        addInst(0, 32'h00001097, 0, 0, -1);
        addInst(0, 32'h008000EF, 0, 0, -1);
        addInst(0, 32'h000080E7, 0, 0, -1);
        addInst(0, 32'h0000A183, 0, 15, -1);
        s = q0.size(); addInst(0, 32'h0020A023, 0, 100, -1); e = q0.size();
        pin("sw_timeout_mem_cycles", countState0(s, e, 3'd3), 16);
        addTrap(0, 4);
        addReset(0, 1);
        s = q0.size(); addInst(0, 32'hFFFFFFFF, 0, 0, -1);
        pin("illegal_cause", int'(q0[s+2].exp.cause), 2'b01);
        addReset(0, 2);
        addInst(0, 32'h0000A183, 0, 4, 1);
        addInst(0, 32'h0020A023, 0, 5, 2);
        for (int i = 0; i < 120; i++) begin
            if (trapped[0]) addReset(0, $urandom_range(1, 2));
            addInst(0, randInst(1), rb(), $urandom_range(0, 17),
                    ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : -1);
        end

        // Single-cycle MEM, NOP-on-illegal instance.
        addReset(1, 2);
        s = q1.size(); addInst(1, 32'hFFFFFFFF, 0, 0, -1);
        pin("illegal_nop_cycles", q1.size() - s, 2);
        addInst(1, 32'h002081B3, 0, 0, -1);
        addInst(1, 32'h0000A183, 0, 5, -1);
        addInst(1, 32'h0020A023, 0, 5, -1);
        for (int i = 0; i < 120; i++) addInst(1, randInst(1), rb(), 0, -1);

        while (q0.size() < q1.size()) addReset(0, 1);
        while (q1.size() < q0.size()) addReset(1, 1);

        for (int cyc = 0; q0.size() > 0; cyc++) begin
            rec_t r0, r1;
            r0 = q0.pop_front();
            r1 = q1.pop_front();
            @(negedge iClk);
            rst0 = r0.rst; bus0.iInst_Code = r0.inst; bus0.iBtaken = r0.bt; bus0.iMem_Ready = r0.rdy;
            rst1 = r1.rst; bus1.iInst_Code = r1.inst; bus1.iBtaken = r1.bt; bus1.iMem_Ready = r1.rdy;
            #1;
            nCmp++;
            if (act0 !== r0.exp) begin
                nBad++;
                $display("FAIL dut0 cycle %0d: got %h, required %h", cyc, act0, r0.exp);
            end
            nCmp++;
            if (act1 !== r1.exp) begin
                nBad++;
                $display("FAIL dut1 cycle %0d: got %h, required %h", cyc, act1, r1.exp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle_control.md
# rv32i_multicycle_control

Multi-cycle control unit for the RV32I core. It replaces the single-cycle decode with a FETCH/DECODE/EXECUTE/MEM/WB state machine, so the datapath can share one ALU and one memory port. It waits on a data-memory ready handshake with a programmable timeout, and it traps on illegal opcodes and on memory timeouts. It sits between the instruction/data memories and the existing datapath (PC, register file, ALU source muxes, write-back mux) and drives the same control signal set the datapath already accepts, plus PC/IR enables.

## Interface
- MEM_HANDSHAKE, 1: 1 = MEM state waits for iMem_Ready; 0 = MEM state lasts exactly one cycle and iMem_Ready is ignored.
- MEM_TIMEOUT, 15: number of unanswered MEM cycles allowed before a trap; 0 = wait forever. Wait-counter width is $clog2(MEM_TIMEOUT+1), minimum 1.
- TRAP_ILLEGAL, 1: 1 = an unknown opcode enters TRAP; 0 = an unknown opcode executes as a NOP (PC+4).
- Clock and reset: one clock; reset is synchronous and active-high (iClk, iRst).
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iInst_Code  in  32  instruction from instruction memory (combinational read at current PC)
- iBtaken  in  1  branch comparison result from the ALU
- iMem_Ready  in  1  data memory has completed the current access
- oIR_En  out  1  load the datapath instruction register
- oPC_En  out  1  update the PC register this cycle
- oPC_Sel  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result (JALR)
- oFunct3  out  3  rInst[14:12]
- oALU_Control  out  4  ALU opcode, {funct7[5], funct3} encoding; ADD = 4'b0000
- oALUSrcMuxSel1  out  1  1 = PC as ALU operand A
- oALUSrcMuxSel2  out  1  1 = immediate as ALU operand B
- oRegWrDataSel  out  2  00 = ALU, 01 = load data, 10 = immediate (LUI), 11 = PC+4
- oWrEn  out  1  register file write enable
- oData_WrEn  out  1  data memory write request
- oData_RdEn  out  1  data memory read request
- oTrap  out  1  core halted in TRAP
- oTrapCause  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none
- oState  out  3  FETCH = 0, DECODE = 1, EXECUTE = 2, MEM = 3, WB = 4, TRAP = 5

## Operation
- Internal register rInst is loaded from iInst_Code in FETCH. All decode uses rInst; iInst_Code is ignored outside FETCH.
- Outputs are combinational from the state register, rInst, iBtaken and iMem_Ready. Any output not listed for a state is 0.
- **FETCH:** oIR_En = 1. Next state is DECODE.
- **DECODE:** classify rInst[6:0].
  - Known opcodes: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. Next state is EXECUTE.
  - Unknown opcode with TRAP_ILLEGAL = 1: next state is TRAP, oTrapCause becomes 01.
  - Unknown opcode with TRAP_ILLEGAL = 0: oPC_En = 1, oPC_Sel = 00, next state is FETCH.
- **EXECUTE:** outputs by instruction type.
  - R: oALU_Control = {f7[5], f3}, oWrEn = 1, oPC_En = 1.
  - I: oALU_Control = {f7[5], f3} when f3 = 101, otherwise {0, f3}. Also Sel2 = 1, oWrEn = 1, oPC_En = 1.
  - LUI: oRegWrDataSel = 10, oWrEn = 1, oPC_En = 1.
  - AUIPC: Sel1 = 1, Sel2 = 1, oWrEn = 1, oPC_En = 1.
  - JAL: oRegWrDataSel = 11, oWrEn = 1, oPC_Sel = 01, oPC_En = 1.
  - JALR: oRegWrDataSel = 11, Sel2 = 1, oWrEn = 1, oPC_Sel = 10, oPC_En = 1.
  - B: oALU_Control = {0, f3}, oPC_En = 1, oPC_Sel = 01 when iBtaken = 1, otherwise 00.
  - L and S: Sel2 = 1 (ADD for address). Next state is MEM.
  - All other types: next state is FETCH.
- **MEM:** Sel2 = 1 is held. oData_RdEn (L) or oData_WrEn (S) is held high for the whole state.
  - The wait counter clears on entry and increments on each cycle with iMem_Ready = 0.
  - Completion: iMem_Ready = 1, or any cycle when MEM_HANDSHAKE = 0.
  - On completion for S: oPC_En = 1, next state is FETCH.
  - On completion for L: next state is WB.
  - Timeout: counter == MEM_TIMEOUT with iMem_Ready = 0 and MEM_TIMEOUT != 0. Next state is TRAP, oTrapCause becomes 10.
  - iMem_Ready = 1 in the cycle the counter equals MEM_TIMEOUT counts as completion, not timeout.
- **WB:** oRegWrDataSel = 01, oWrEn = 1, oPC_En = 1. Next state is FETCH.
- **TRAP:** sticky. oTrap = 1, oTrapCause is held, and all enables are 0 until iRst.

## Timing
- Reset: iRst sampled high puts the state in FETCH and clears rInst, the wait counter and oTrapCause.
  - While iRst is high, every output is forced to 0 except oState = 0.
  - The first FETCH is the first cycle after iRst falls.
  - Reset mid-MEM drops oData_RdEn/oData_WrEn in the same cycle.
- Latency in cycles:
  - R, I, LUI, AUIPC, JAL, JALR and B: 3.
  - S: 4 + wait cycles.
  - L: 5 + wait cycles.
  - Worst-case MEM residency is MEM_TIMEOUT+1 cycles.
- oPC_En is asserted for exactly one cycle per retired instruction. oWrEn is asserted for at most one cycle per instruction.
- iBtaken is sampled only in the EXECUTE cycle of a B instruction.

## Test plan
- ADD 0x002081B3, then SUB 0x402081B3 -> each takes 3 cycles. EXECUTE shows oALU_Control 0000 / 1000, oWrEn = 1, oPC_En = 1, oPC_Sel = 00.
- SRAI 0x4020D193 -> oALU_Control = 1101, Sel2 = 1. ADDI with bit 30 set (0x4020 8193) -> oALU_Control = 0000.
- BEQ 0x00208463 with iBtaken = 1 -> oPC_Sel = 01. With iBtaken = 0 -> oPC_Sel = 00. oWrEn = 0 in both cases.
- LW 0x0000A183 with iMem_Ready high on the 3rd MEM cycle -> oData_RdEn high for 3 cycles, then WB with oRegWrDataSel = 01, oWrEn = 1. Total 7 cycles.
- SW 0x0020A023 with iMem_Ready stuck at 0, MEM_TIMEOUT = 15 -> 16 MEM cycles, then TRAP with oTrapCause = 10, held until iRst.
- Fetch 0xFFFFFFFF -> TRAP after DECODE with oTrapCause = 01. With TRAP_ILLEGAL = 0 -> oPC_En pulses in DECODE, then FETCH. Asserting iRst mid-MEM returns to FETCH with all enables 0.
